// File: rtl/param_mul_and_acc.sv
// param_mul_and_acc: sequential shift-add multiply-accumulate unit.
// It accepts one operand pair in IDLE and then spends DATA_W cycles in MUL,
// doing one shift-add step per cycle. It then spends one cycle in ACC,
// where the signed or unsigned product is folded into the accumulator.
// Optional feature macro: PMAC_SATURATE_EN. When it is defined, an
// overflowing accumulate clamps to the mode's extreme value. Otherwise the
// accumulator wraps modulo 2^ACC_W. The overflow flag is sticky in both builds.
module param_mul_and_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              pmac_clk_i,
  input  logic              pmac_reset_i,
  input  logic [DATA_W-1:0] pmac_multiplicand_i,
  input  logic [DATA_W-1:0] pmac_multiplier_i,
  input  logic              pmac_valid_i,
  input  logic              pmac_signed_i,
  input  logic              pmac_clear_i,
  output logic [ACC_W-1:0]  pmac_result_o,
  output logic              fetching_input_o,
  output logic              updating_acc_result_o,
  output logic              pmac_overflow_o
);

  localparam int CNT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              idle_clear;
  logic              last_step;

  // Operands captured at accept, kept as magnitudes plus a product sign.
  logic [PROD_W-1:0] mcand_p0;
  logic [DATA_W-1:0] mplier_p0;
  logic [PROD_W-1:0] prod_p0;
  logic              neg_p0;
  logic              sgn_p0;
  logic              clr_p0;

  // Accumulate-stage combinational values.
  logic [ACC_W-1:0]  prod_ext_p1;
  logic [ACC_W-1:0]  addend_p1;
  logic [ACC_W-1:0]  base_p1;
  logic [ACC_W:0]    sum_wide_p1;
  logic [ACC_W-1:0]  sum_p1;
  logic              ovf_p1;
  logic [ACC_W-1:0]  next_acc_p1;

  // Magnitude of an operand. The most negative value maps to 2^(DATA_W-1),
  // which still fits in DATA_W unsigned bits, so no precision is lost.
  function automatic logic [DATA_W-1:0] to_mag(input logic [DATA_W-1:0] x,
                                               input logic sgn);
    if (sgn && x[DATA_W-1])
      return ~x + 1'b1;
    else
      return x;
  endfunction

  // Signed mode: operands share a sign and the sum's sign differs.
  // Unsigned mode: carry out of the top accumulator bit.
  function automatic logic detect_ovf(input logic sgn,
                                      input logic base_msb,
                                      input logic add_msb,
                                      input logic sum_msb,
                                      input logic carry);
    if (sgn)
      return (base_msb == add_msb) && (sum_msb != base_msb);
    else
      return carry;
  endfunction

  // Extreme value for the active mode. In signed mode the overflow direction
  // follows the sign of the operands, which is the same as the base's sign.
  function automatic logic [ACC_W-1:0] sat_value(input logic sgn,
                                                 input logic base_msb);
    if (!sgn)
      return {ACC_W{1'b1}};
    else if (base_msb)
      return {1'b1, {(ACC_W-1){1'b0}}};
    else
      return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  assign accept     = (state == IDLE) && pmac_valid_i;
  assign idle_clear = (state == IDLE) && !pmac_valid_i && pmac_clear_i;
  assign last_step  = (cnt == CNT_W'(DATA_W - 1));

  // State register and MUL step counter.
  always_ff @(posedge pmac_clk_i) begin
    if (pmac_reset_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == MUL)
        cnt <= last_step ? '0 : cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next            = state;
    fetching_input_o      = 1'b0;
    updating_acc_result_o = 1'b0;
    case (state)
      IDLE: begin
        fetching_input_o = 1'b1;
        if (pmac_valid_i)
          state_next = MUL;
      end
      MUL: begin
        if (last_step)
          state_next = ACC;
      end
      ACC: begin
        updating_acc_result_o = 1'b1;
        state_next            = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---- stage p0: operand capture and shift-add multiply ----
  // Captures operands at accept, then performs one shift-add step per MUL cycle.
  always_ff @(posedge pmac_clk_i) begin
    if (accept) begin
      mcand_p0  <= PROD_W'(to_mag(pmac_multiplicand_i, pmac_signed_i));
      mplier_p0 <= to_mag(pmac_multiplier_i, pmac_signed_i);
      prod_p0   <= '0;
      neg_p0    <= pmac_signed_i &
                   (pmac_multiplicand_i[DATA_W-1] ^ pmac_multiplier_i[DATA_W-1]);
      sgn_p0    <= pmac_signed_i;
      clr_p0    <= pmac_clear_i;
    end else if (state == MUL) begin
      prod_p0   <= prod_p0 + (mplier_p0[0] ? mcand_p0 : '0);
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // ---- stage p1: sign restore, accumulate, overflow and clamp ----
  // Forms the accumulate result from the finished product and the current sum.
  always_comb begin
    prod_ext_p1 = ACC_W'(prod_p0);
    addend_p1   = neg_p0 ? (~prod_ext_p1 + 1'b1) : prod_ext_p1;
    base_p1     = clr_p0 ? '0 : pmac_result_o;
    sum_wide_p1 = {1'b0, base_p1} + {1'b0, addend_p1};
    sum_p1      = sum_wide_p1[ACC_W-1:0];
    ovf_p1      = detect_ovf(sgn_p0, base_p1[ACC_W-1], addend_p1[ACC_W-1],
                             sum_p1[ACC_W-1], sum_wide_p1[ACC_W]);
`ifdef PMAC_SATURATE_EN
    next_acc_p1 = ovf_p1 ? sat_value(sgn_p0, base_p1[ACC_W-1]) : sum_p1;
`else
    next_acc_p1 = sum_p1;
`endif
  end

  // Accumulator and sticky overflow. Both are updated in ACC and zeroed by a
  // clear in IDLE or by reset.
  always_ff @(posedge pmac_clk_i) begin
    if (pmac_reset_i) begin
      pmac_result_o   <= '0;
      pmac_overflow_o <= 1'b0;
    end else if (state == ACC) begin
      pmac_result_o   <= next_acc_p1;
      pmac_overflow_o <= clr_p0 ? ovf_p1 : (pmac_overflow_o | ovf_p1);
    end else if (idle_clear) begin
      pmac_result_o   <= '0;
      pmac_overflow_o <= 1'b0;
    end
  end

endmodule

// File: doc/param_mul_and_acc.md
PARAM_MUL_AND_ACC -- requirements
Module: param_mul_and_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits (>=2).
REQ-002 SHALL have parameter ACC_W, default 24, accumulator width in bits (>=2*DATA_W).
REQ-003 SHALL have port pmac_clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port pmac_reset_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pmac_multiplicand_i, input, DATA_W, operand A.
REQ-006 SHALL have port pmac_multiplier_i, input, DATA_W, operand B.
REQ-007 SHALL have port pmac_valid_i, input, 1, operands offered this cycle.
REQ-008 SHALL have port pmac_signed_i, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled at accept.
REQ-009 SHALL have port pmac_clear_i, input, 1, restart accumulation from zero; sampled at accept or in IDLE.
REQ-010 SHALL have port pmac_result_o, output, ACC_W, accumulator value.
REQ-011 SHALL have port fetching_input_o, output, 1, ready; high only in IDLE.
REQ-012 SHALL have port updating_acc_result_o, output, 1, one-cycle pulse in the cycle pmac_result_o takes a new sum.
REQ-013 SHALL have port pmac_overflow_o, output, 1, sticky accumulate-overflow flag.

Function
REQ-014 SHALL implement FSM IDLE -> MUL -> ACC -> IDLE.
REQ-015 Accept SHALL occur on a rising edge where state = IDLE and pmac_valid_i = 1; operands, signed mode and clear are registered, state -> MUL.
REQ-016 In signed mode, operands SHALL be converted to magnitudes at accept and the product sign recorded as XOR of operand signs.
REQ-017 MUL SHALL last exactly DATA_W cycles, one shift-add step per cycle, multiplier bit 0 first; the cycle counter SHALL count 0..DATA_W-1.
REQ-018 ACC SHALL last one cycle: product (negated if sign set) sign-extended (signed) or zero-extended (unsigned) to ACC_W, then added to the accumulator, or to zero if the registered clear was set.
REQ-019 updating_acc_result_o SHALL be high exactly during ACC; the new pmac_result_o SHALL be visible after the edge ending ACC.
REQ-020 Latency SHALL be DATA_W+1 edges from accept to result; throughput SHALL be one operation per DATA_W+2 cycles with pmac_valid_i held high.
REQ-021 pmac_clear_i high in IDLE with pmac_valid_i low SHALL zero pmac_result_o and pmac_overflow_o on the next edge, without pulsing updating_acc_result_o.
REQ-022 pmac_valid_i, pmac_clear_i and operand changes outside IDLE SHALL be ignored.
REQ-023 Overflow SHALL be detected per mode: signed overflow (signed) or carry-out of bit ACC_W-1 (unsigned); detection SHALL set pmac_overflow_o until clear or reset.
REQ-024 Operand value -2^(DATA_W-1) in signed mode SHALL produce the exact product (magnitude 2^(DATA_W-1) handled without truncation).

Reset
REQ-025 With pmac_reset_i high at an edge: state -> IDLE, pmac_result_o = 0, pmac_overflow_o = 0, updating_acc_result_o = 0, counter = 0; fetching_input_o = 1 after that edge.
REQ-026 Reset SHALL override all other inputs, including mid-MUL or in ACC, discarding the operation in flight.

Configuration
REQ-027 Macro PMAC_SATURATE_EN defined: on overflow, the accumulator SHALL clamp to the mode's extreme (signed: 2^(ACC_W-1)-1 or -2^(ACC_W-1); unsigned: 2^ACC_W-1); pmac_overflow_o is still set.
REQ-028 Macro PMAC_SATURATE_EN undefined: the accumulator SHALL wrap modulo 2^ACC_W; pmac_overflow_o is still set.

Verification (DATA_W=8, ACC_W=24)
REQ-029 Reset, accept unsigned 3*5 with clear, then 7*9 -> result 0x00000F, then 0x00004E; each preceded by one updating_acc_result_o pulse 9 edges after its accept.
REQ-030 Signed -3*5 with clear, then -128*-128 -> 0xFFFFF1, then 0x003FF1; pmac_overflow_o stays 0.
REQ-031 Unsigned accumulator at 0xFFFF00 (preloaded by repeated ops), add 255*255 -> PMAC_SATURATE_EN defined: 0xFFFFFF; undefined: 0x00FD01; pmac_overflow_o = 1 in both cases.
REQ-032 pmac_valid_i held high for 4 operations of 1*1 with no clear after reset -> result 1,2,3,4; fetching_input_o high exactly one cycle in every 10.
REQ-033 Assert reset during the 4th MUL cycle of 200*200 -> result 0, no pulse, fetching_input_o = 1 next cycle; subsequent 2*2 with clear -> 0x000004.
REQ-034 With pmac_clear_i high while in MUL -> ignored and the sum completes normally; then pmac_clear_i in IDLE without pmac_valid_i -> result 0, overflow 0, no pulse.
